// File: rtl/mem_access_unit_if.sv
// Bundle of request/response and data-memory signals for mem_access_unit.
// The slave modport is the unit's view; the master modport is the
// environment's view (execute stage plus data memory).
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    // Request side
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_wide;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    // Response side
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    // Data memory side
    logic              mem_read_enable;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [15:0]       mem_read_data;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [15:0]       mem_write_data;

    modport slave (
        input  req_valid, req_write, req_wide, req_addr, req_wdata, mem_read_data,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_read_enable, mem_read_addr,
        output mem_write_enable, mem_write_addr, mem_write_data
    );

    modport master (
        output req_valid, req_write, req_wide, req_addr, req_wdata, mem_read_data,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_read_enable, mem_read_addr,
        input  mem_write_enable, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage sequencer: takes one 16/32-bit load or store at a time,
// splits wide accesses into two 16-bit beats (high half at addr, low half
// at addr+1), range-checks the address and returns one response per request.
// Every output is driven straight from a register.
module mem_access_unit #(
    parameter int MEM_DEPTH = 1000000,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD_LO_ISSUE,
        RD_WAIT,
        RD_CAP_HI,
        RD_CAP_LO,
        WR_LO,
        DONE_ST,
        ERR
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_WIDE = ADDR_W'(MEM_DEPTH - 2);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       hi_q, hi_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              range_err;

    // A wide access needs addr+1 in range too, so addr+1 can never wrap.
    assign range_err = (bus.req_addr > LAST_ADDR) ||
                       (bus.req_wide && (bus.req_addr > LAST_WIDE));

    // Next-state and next-output logic; beat sequencing lives here.
    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        hi_d        = hi_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (range_err) begin
                        state_d = ERR;
                    end else if (!bus.req_write) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = bus.req_addr;
                        state_d   = bus.req_wide ? RD_LO_ISSUE : RD_WAIT;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = bus.req_addr;
                        wr_data_d = bus.req_wide ? bus.req_wdata[31:16] : bus.req_wdata[15:0];
                        state_d   = bus.req_wide ? WR_LO : DONE_ST;
                    end
                end
            end
            RD_LO_ISSUE: begin
                rd_en_d   = 1'b1;
                rd_addr_d = addr_q + ADDR_W'(1);
                state_d   = RD_CAP_HI;
            end
            RD_WAIT: begin
                hi_d    = 16'h0;
                state_d = RD_CAP_LO;
            end
            RD_CAP_HI: begin
                hi_d    = bus.mem_read_data;
                state_d = RD_CAP_LO;
            end
            RD_CAP_LO: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = {hi_q, bus.mem_read_data};
                state_d     = IDLE;
            end
            WR_LO: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q + ADDR_W'(1);
                wr_data_d = wdata_q[15:0];
                state_d   = DONE_ST;
            end
            DONE_ST: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 32'h0;
                state_d     = IDLE;
            end
            ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = 32'h0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Ready is high exactly while the unit sits in IDLE.
        ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            hi_q        <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            hi_q        <= hi_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.req_ready        = ready_q;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_err          = rsp_err_q;
    assign bus.rsp_rdata        = rsp_rdata_q;
    assign bus.mem_read_enable  = rd_en_q;
    assign bus.mem_read_addr    = rd_addr_q;
    assign bus.mem_write_enable = wr_en_q;
    assign bus.mem_write_addr   = wr_addr_q;
    assign bus.mem_write_data   = wr_data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 16-bit data memory:
// reads sampled at posedge, writes applied at negedge.
module tb_mem_access_unit;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.MEM_DEPTH(1000000), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory
    logic [15:0] mem [int unsigned];

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 16'h0;
    endfunction

    initial bus.mem_read_data = 16'h0;

    always @(posedge clk)
        if (bus.mem_read_enable === 1'b1) bus.mem_read_data <= mem_rd(bus.mem_read_addr);

    always @(negedge clk)
        if (bus.mem_write_enable === 1'b1) mem[bus.mem_write_addr] = bus.mem_write_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Read and write enables must never be high together.
    always @(negedge clk)
        if (mon_on) check_bit("no_enable_overlap",
                              bus.mem_read_enable & bus.mem_write_enable, 1'b0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic wide, input logic [31:0] a,
                         input logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_wide  = wide;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    task automatic check_idle_zero(input string tag);
        check_bit({tag, "_ready"}, bus.req_ready, 1'b1);
        check_bit({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check_bit({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
        check_bit({tag, "_re"}, bus.mem_read_enable, 1'b0);
        check({tag, "_raddr"}, bus.mem_read_addr, 32'h0);
        check_bit({tag, "_we"}, bus.mem_write_enable, 1'b0);
        check({tag, "_waddr"}, bus.mem_write_addr, 32'h0);
        check({tag, "_wdata"}, {16'h0, bus.mem_write_data}, 32'h0);
    endtask

    // Stream stimulus: narrow store, wide store, wide load of the stored word
    logic        s_w     [3] = '{1'b1, 1'b1, 1'b0};
    logic        s_wide  [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] s_addr  [3] = '{32'h30, 32'h40, 32'h40};
    logic [31:0] s_wdata [3] = '{32'h0000_4444, 32'hCAFE_D00D, 32'h0};
    logic [31:0] s_exp   [3] = '{32'h0, 32'h0, 32'hCAFE_D00D};
    int          s_lat   [3] = '{1, 2, 3};

    initial begin
        int   idx;
        int   nrsp;
        int   cyc;
        int   due;
        logic rdy_before;

        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_wide  = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        mem[32'd999998] = 16'hAAAA;
        mem[32'd999999] = 16'h5555;

        // Reset state
        step();
        step();
        mon_on = 1'b1;
        check_idle_zero("reset");
        rst = 1'b1;
        step();

        // Narrow store 0x10 <- 0xBEEF
        drive(1'b1, 1'b0, 32'h10, 32'h0000_BEEF);
        step();
        bus.req_valid = 1'b0;
        check_bit("nst_A_we", bus.mem_write_enable, 1'b1);
        check("nst_A_waddr", bus.mem_write_addr, 32'h10);
        check("nst_A_wdata", {16'h0, bus.mem_write_data}, 32'h0000_BEEF);
        check_bit("nst_A_ready", bus.req_ready, 1'b0);
        check_bit("nst_A_rsp", bus.rsp_valid, 1'b0);
        step();
        check_bit("nst_A1_rsp", bus.rsp_valid, 1'b1);
        check_bit("nst_A1_err", bus.rsp_err, 1'b0);
        check("nst_A1_rdata", bus.rsp_rdata, 32'h0);
        check_bit("nst_A1_we", bus.mem_write_enable, 1'b0);
        check_bit("nst_A1_ready", bus.req_ready, 1'b1);
        check("nst_mem10", {16'h0, mem_rd(32'h10)}, 32'h0000_BEEF);

        // Narrow load of the same address, presented in the response cycle
        drive(1'b0, 1'b0, 32'h10, 32'h0);
        step();
        bus.req_valid = 1'b0;
        check_bit("nld_A_re", bus.mem_read_enable, 1'b1);
        check("nld_A_raddr", bus.mem_read_addr, 32'h10);
        check_bit("nld_A_rsp_clear", bus.rsp_valid, 1'b0);
        step();
        check_bit("nld_A1_re", bus.mem_read_enable, 1'b0);
        check_bit("nld_A1_rsp", bus.rsp_valid, 1'b0);
        step();
        check_bit("nld_A2_rsp", bus.rsp_valid, 1'b1);
        check_bit("nld_A2_err", bus.rsp_err, 1'b0);
        check("nld_A2_rdata", bus.rsp_rdata, 32'h0000_BEEF);
        check_bit("nld_A2_ready", bus.req_ready, 1'b1);
        step();
        check_bit("nld_pulse", bus.rsp_valid, 1'b0);

        // Wide store 0x20 <- 0x12345678
        drive(1'b1, 1'b1, 32'h20, 32'h1234_5678);
        step();
        bus.req_valid = 1'b0;
        check_bit("wst_A_we", bus.mem_write_enable, 1'b1);
        check("wst_A_waddr", bus.mem_write_addr, 32'h20);
        check("wst_A_wdata", {16'h0, bus.mem_write_data}, 32'h0000_1234);
        step();
        check_bit("wst_A1_we", bus.mem_write_enable, 1'b1);
        check("wst_A1_waddr", bus.mem_write_addr, 32'h21);
        check("wst_A1_wdata", {16'h0, bus.mem_write_data}, 32'h0000_5678);
        check_bit("wst_A1_rsp", bus.rsp_valid, 1'b0);
        step();
        check_bit("wst_A2_we", bus.mem_write_enable, 1'b0);
        check_bit("wst_A2_rsp", bus.rsp_valid, 1'b1);
        check("wst_A2_rdata", bus.rsp_rdata, 32'h0);
        check("wst_mem20", {16'h0, mem_rd(32'h20)}, 32'h0000_1234);
        check("wst_mem21", {16'h0, mem_rd(32'h21)}, 32'h0000_5678);
        check("wst_hold_waddr", bus.mem_write_addr, 32'h21);
        step();

        // Wide load 0x20
        drive(1'b0, 1'b1, 32'h20, 32'h0);
        step();
        bus.req_valid = 1'b0;
        check_bit("wld_A_re", bus.mem_read_enable, 1'b1);
        check("wld_A_raddr", bus.mem_read_addr, 32'h20);
        step();
        check_bit("wld_A1_re", bus.mem_read_enable, 1'b1);
        check("wld_A1_raddr", bus.mem_read_addr, 32'h21);
        check_bit("wld_A1_rsp", bus.rsp_valid, 1'b0);
        step();
        check_bit("wld_A2_re", bus.mem_read_enable, 1'b0);
        check_bit("wld_A2_rsp", bus.rsp_valid, 1'b0);
        step();
        check_bit("wld_A3_rsp", bus.rsp_valid, 1'b1);
        check("wld_A3_rdata", bus.rsp_rdata, 32'h1234_5678);
        check_bit("wld_A3_err", bus.rsp_err, 1'b0);
        step();

        // Wide load at the last legal wide address
        drive(1'b0, 1'b1, 32'd999998, 32'h0);
        step();
        bus.req_valid = 1'b0;
        check("edge_A_raddr", bus.mem_read_addr, 32'd999998);
        step();
        step();
        step();
        check_bit("edge_A3_rsp", bus.rsp_valid, 1'b1);
        check_bit("edge_A3_err", bus.rsp_err, 1'b0);
        check("edge_A3_rdata", bus.rsp_rdata, 32'hAAAA_5555);
        step();

        // Wide load at 999999: out of range
        drive(1'b0, 1'b1, 32'd999999, 32'h0);
        step();
        bus.req_valid = 1'b0;
        check_bit("werr_A_re", bus.mem_read_enable, 1'b0);
        check_bit("werr_A_ready", bus.req_ready, 1'b0);
        check_bit("werr_A_rsp", bus.rsp_valid, 1'b0);
        step();
        check_bit("werr_A1_rsp", bus.rsp_valid, 1'b1);
        check_bit("werr_A1_err", bus.rsp_err, 1'b1);
        check("werr_A1_rdata", bus.rsp_rdata, 32'h0);
        check_bit("werr_A1_re", bus.mem_read_enable, 1'b0);
        check_bit("werr_A1_ready", bus.req_ready, 1'b1);
        step();
        check_bit("werr_pulse_valid", bus.rsp_valid, 1'b0);
        check_bit("werr_pulse_err", bus.rsp_err, 1'b0);

        // Narrow load at 1000000: out of range
        drive(1'b0, 1'b0, 32'd1000000, 32'h0);
        step();
        bus.req_valid = 1'b0;
        check_bit("nerr_A_re", bus.mem_read_enable, 1'b0);
        step();
        check_bit("nerr_A1_rsp", bus.rsp_valid, 1'b1);
        check_bit("nerr_A1_err", bus.rsp_err, 1'b1);
        check("nerr_A1_rdata", bus.rsp_rdata, 32'h0);
        check_bit("nerr_A1_re", bus.mem_read_enable, 1'b0);
        step();

        // Three back-to-back requests with req_valid held high
        idx  = 0;
        nrsp = 0;
        cyc  = 0;
        due  = -1;
        drive(s_w[0], s_wide[0], s_addr[0], s_wdata[0]);
        while (nrsp < 3 && cyc < 40) begin
            rdy_before = bus.req_ready;
            step();
            cyc++;
            if (rdy_before && bus.req_valid) begin
                due = cyc + s_lat[idx];
                idx++;
                if (idx < 3) drive(s_w[idx], s_wide[idx], s_addr[idx], s_wdata[idx]);
                else bus.req_valid = 1'b0;
            end
            check_bit("stream_rsp_valid", bus.rsp_valid, cyc == due);
            check_bit("stream_ready", bus.req_ready, cyc == due);
            if (bus.rsp_valid === 1'b1) begin
                if (nrsp < 3) check("stream_rdata", bus.rsp_rdata, s_exp[nrsp]);
                nrsp++;
            end
        end
        bus.req_valid = 1'b0;
        check("stream_rsp_count", nrsp, 32'd3);
        check("stream_accept_count", idx, 32'd3);
        check("stream_mem30", {16'h0, mem_rd(32'h30)}, 32'h0000_4444);
        check("stream_mem40", {16'h0, mem_rd(32'h40)}, 32'h0000_CAFE);
        check("stream_mem41", {16'h0, mem_rd(32'h41)}, 32'h0000_D00D);
        step();

        // Reset sampled at A+1 of a wide load drops it
        drive(1'b0, 1'b1, 32'h20, 32'h0);
        step();
        bus.req_valid = 1'b0;
        check_bit("rst_A_re", bus.mem_read_enable, 1'b1);
        rst = 1'b0;
        step();
        check_idle_zero("midrst");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_bit("midrst_no_rsp", bus.rsp_valid, 1'b0);
        end

        // Fresh narrow load after reset
        drive(1'b0, 1'b0, 32'h21, 32'h0);
        step();
        bus.req_valid = 1'b0;
        check("post_A_raddr", bus.mem_read_addr, 32'h21);
        step();
        check_bit("post_A1_rsp", bus.rsp_valid, 1'b0);
        step();
        check_bit("post_A2_rsp", bus.rsp_valid, 1'b1);
        check("post_A2_rdata", bus.rsp_rdata, 32'h0000_5678);
        step();

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage sequencer between the execute stage and the 16-bit data memory.
- Accepts one load or store request at a time, either narrow (16-bit) or wide (32-bit).
- Wide accesses are split into two 16-bit beats (high half at addr, low half at addr+1).
- Drives the memory's read/write enables, addresses and write data; collects read data and returns one response per request.

Parameters:
- MEM_DEPTH, 1000000, number of 16-bit words in data memory; valid word addresses are 0..MEM_DEPTH-1.
- ADDR_W, 32, address width.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept (high only in IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_wide  input  1  1 = 32-bit access, 0 = 16-bit access.
- req_addr  input  32  word address.
- req_wdata  input  32  store data; narrow stores use [15:0].
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_err  output  1  qualifies rsp_valid: address out of range.
- rsp_rdata  output  32  load data; zero for stores and errors.
- mem_read_enable  output  1  to memory read_enable.
- mem_read_addr  output  32  to memory read_addr.
- mem_read_data  input  16  from memory read_data.
- mem_write_enable  output  1  to memory write_enable.
- mem_write_addr  output  32  to memory write_addr.
- mem_write_data  output  16  to memory write_data.

Behaviour:
- **Registered outputs:** all outputs are registered.
- **Memory timing contract:**
  - Memory samples the read enable/address at the posedge after the unit drives them, and updates mem_read_data at that edge.
  - The unit captures mem_read_data one edge later.
  - Memory writes on the negedge within the cycle the write enable is high.
- **Reset (rst=0 at a posedge):**
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0.
  - All mem_* enables, addresses and data = 0.
  - An in-flight request is dropped with no response.
- **Accept:** at posedge A with req_valid & req_ready, latch write, wide, addr and wdata; req_ready goes 0 from A.
- **Range check at accept:**
  - Error if addr > MEM_DEPTH-1, or if wide and addr > MEM_DEPTH-2 (no addr+1 wrap).
  - On error: no memory enable is asserted; state ERR; at A+1 rsp_valid=1, rsp_err=1, rsp_rdata=0; return to IDLE.
- **Narrow load:**
  - A: mem_read_enable=1, mem_read_addr=addr.
  - A+1: enable=0.
  - A+2: rsp_rdata={16'h0, mem_read_data}, rsp_valid=1.
- **Wide load (pipelined beats):**
  - A: read addr.
  - A+1: read addr+1.
  - A+2: enable=0; capture high half.
  - A+3: capture low half; rsp_rdata={hi, lo}; rsp_valid=1.
- **Narrow store:**
  - A: mem_write_enable=1, mem_write_addr=addr, mem_write_data=wdata[15:0].
  - A+1: enable=0, rsp_valid=1, rsp_rdata=0.
- **Wide store:**
  - A: write addr with wdata[31:16].
  - A+1: write addr+1 with wdata[15:0].
  - A+2: enable=0, rsp_valid=1.
- **Pulses:** rsp_valid and rsp_err are one-cycle pulses.
- **Return to IDLE:** the unit is in IDLE with req_ready=1 in the cycle rsp_valid is high, so the next request can be accepted at the following edge. Minimum spacing is the response edge +1.
- **States:** IDLE, RD_LO_ISSUE, RD_WAIT, RD_CAP_HI, RD_CAP_LO, WR_LO, DONE_ST, ERR.
- **Transitions:**
  - IDLE → RD_LO_ISSUE (wide load) | RD_WAIT (narrow load) | WR_LO (wide store) | DONE_ST (narrow store) | ERR.
  - RD_LO_ISSUE → RD_CAP_HI → RD_CAP_LO → IDLE.
  - RD_WAIT → RD_CAP_LO → IDLE.
  - WR_LO → DONE_ST → IDLE.
  - ERR → IDLE.
- **Never** assert mem_read_enable and mem_write_enable in the same cycle.
- **While busy:** req_* inputs are ignored; requester changes have no effect.
- **Address arithmetic:** addr+1 is computed 32-bit; overflow cannot occur because of the range check.
- **Unused address/data outputs:** hold their last value when enables are 0, except after reset, when they are 0.

Test Plan:
- Narrow store addr 0x10 wdata 0x0000BEEF, then narrow load 0x10 -> memory[0x10]=0xBEEF; load rsp_valid at A+2, rsp_rdata=0x0000BEEF, rsp_err=0.
- Wide store addr 0x20 wdata 0x12345678, then wide load 0x20 -> memory[0x20]=0x1234, memory[0x21]=0x5678; load rsp_valid exactly at A+3 with rsp_rdata=0x12345678.
- Wide load addr 999998 -> normal response; wide load addr 999999 and narrow load addr 1000000 -> rsp_err=1 at A+1, rsp_rdata=0, mem_read_enable never high.
- req_valid held high continuously with 3 queued requests -> req_ready low while busy, each request accepted once, responses in order, no enable overlap.
- rst=0 during a wide load at A+1 -> all outputs 0 next edge, no rsp_valid, req_ready=1; a new narrow load afterwards completes normally at A+2.
- Narrow store immediately followed by a load of the same address -> load returns the stored value (write at negedge precedes read).
